// File: rtl/frg_bist_driver_if.sv
// Stimulus/response link between the BIST driver (master) and the unit under test (slave).
interface frg_bist_driver_if #(
  parameter int IN_W  = 28,
  parameter int OUT_W = 3
);
  logic [IN_W-1:0]  stim;
  logic [OUT_W-1:0] resp;

  modport master (output stim, input resp);
  modport slave  (input stim, output resp);
endinterface

// File: rtl/frg_bist_driver.sv
// LFSR-stimulus / MISR-compaction self-test driver for a combinational decode unit.
module frg_bist_driver #(
  parameter int              IN_W    = 28,
  parameter int              OUT_W   = 3,
  parameter int              MISR_W  = 16,
  parameter int              PAT_CNT = 1024,
  parameter int              SETTLE  = 0,
  parameter logic [IN_W-1:0] SEED    = 28'h0000001
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 seed_ld,
  input  logic [IN_W-1:0]      seed,
  input  logic [MISR_W-1:0]    golden,
  frg_bist_driver_if.master    dut_if,
  output logic                 busy,
  output logic                 done,
  output logic [MISR_W-1:0]    signature,
  output logic                 pass
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [19:0]       PAT_LAST  = 20'(PAT_CNT - 1);
  localparam logic [3:0]        SETTLE_V  = 4'(SETTLE);
  localparam logic [MISR_W-1:0] MISR_POLY = 16'hD008;
  localparam logic [IN_W-1:0]   ONE       = 28'h0000001;

  state_e              state_q, state_d;
  logic [IN_W-1:0]     stim_q, stim_d, stim_ld;
  logic [MISR_W-1:0]   sig_q, sig_d, golden_q, golden_d, misr_nxt;
  logic [19:0]         pat_q, pat_d;
  logic [3:0]          hold_q, hold_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                accept, capture, last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      stim_q   <= SEED;
      sig_q    <= '0;
      golden_q <= '0;
      pat_q    <= '0;
      hold_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      stim_q   <= stim_d;
      sig_q    <= sig_d;
      golden_q <= golden_d;
      pat_q    <= pat_d;
      hold_q   <= hold_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign accept  = (state_q != RUN) && start;
  assign capture = (state_q == RUN) && (hold_q == SETTLE_V);
  assign last    = capture && (pat_q == PAT_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = RUN;
      RUN:        if (last)  state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    stim_ld  = seed_ld ? seed : SEED;
    misr_nxt = {sig_q[MISR_W-2:0], 1'b0}
             ^ (sig_q[MISR_W-1] ? MISR_POLY : '0)
             ^ {{(MISR_W-OUT_W){1'b0}}, dut_if.resp};

    stim_d   = stim_q;
    sig_d    = sig_q;
    golden_d = golden_q;
    pat_d    = pat_q;
    hold_d   = hold_q;
    busy_d   = busy_q;
    done_d   = done_q;

    if (accept) begin
      // An all-zero seed would lock the LFSR, so it is forced to 1.
      stim_d   = (stim_ld == '0) ? ONE : stim_ld;
      sig_d    = '0;
      golden_d = golden;
      pat_d    = '0;
      hold_d   = '0;
      busy_d   = 1'b1;
      done_d   = 1'b0;
    end else if (state_q == RUN) begin
      if (capture) begin
        sig_d  = misr_nxt;
        stim_d = {stim_q[IN_W-2:0], stim_q[IN_W-1] ^ stim_q[IN_W-4]};
        hold_d = '0;
        pat_d  = pat_q + 20'd1;
        if (last) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end else begin
        hold_d = hold_q + 4'd1;
      end
    end
  end

  assign dut_if.stim = stim_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign signature   = sig_q;
  assign pass        = done_q && (sig_q == golden_q);

endmodule
